// File: rtl/mult4_seq_arb.sv
// Round-robin arbiter sharing one external 4x4 multiplier core among NREQ requesters.
// Each accepted request is an 8x8 unsigned multiply done in four shift-accumulate core passes.
module mult4_seq_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned OPW  = 8,
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*OPW-1:0]    req_a,
    input  logic [NREQ*OPW-1:0]    req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [2*OPW-1:0]       rsp_p,
    output logic                   busy,
    output logic [OPW/2-1:0]       core_x,
    output logic [OPW/2-1:0]       core_y,
    input  logic [OPW-1:0]         core_o
);

    localparam int unsigned NW = OPW / 2;
    localparam int unsigned PW = 2 * OPW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_rr_ptr;
    logic [1:0]       r_step;
    logic [PW-1:0]    r_acc;
    logic [OPW-1:0]   r_a;
    logic [OPW-1:0]   r_b;
    logic [IDW-1:0]   r_id;
    logic             r_rsp_valid;
    logic [PW-1:0]    r_rsp_p;
    logic [IDW-1:0]   r_rsp_id;

    logic             w_found;
    logic [IDW-1:0]   w_grant;
    logic [IDW-1:0]   w_idx;
    logic [OPW-1:0]   w_sel_a;
    logic [OPW-1:0]   w_sel_b;
    logic [PW-1:0]    w_term;
    logic [PW-1:0]    w_sum;

    // Round-robin scan: first valid requester at or after r_rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = IDW'((32'(r_rr_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (32'(w_grant) == k) begin
                w_sel_a = req_a[k*OPW +: OPW];
                w_sel_b = req_b[k*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_MUL;
            S_MUL:   if (r_step == 2'd3) w_next = S_DONE;
            S_DONE:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Grant and core operand steering; core inputs are parked at zero outside MUL.
    always_comb begin
        req_ready = '0;
        core_x    = '0;
        core_y    = '0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !rst) req_ready[w_grant] = 1'b1;
            end
            S_MUL: begin
                busy = 1'b1;
                case (r_step)
                    2'd0: begin core_x = r_a[NW-1:0];   core_y = r_b[NW-1:0];   end
                    2'd1: begin core_x = r_a[NW-1:0];   core_y = r_b[OPW-1:NW]; end
                    2'd2: begin core_x = r_a[OPW-1:NW]; core_y = r_b[NW-1:0];   end
                    default: begin core_x = r_a[OPW-1:NW]; core_y = r_b[OPW-1:NW]; end
                endcase
            end
            S_DONE:  busy = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    always_comb begin
        w_term = PW'(core_o);
        case (r_step)
            2'd0:    w_term = PW'(core_o);
            2'd3:    w_term = PW'(core_o) << OPW;
            default: w_term = PW'(core_o) << NW;
        endcase
        w_sum = r_acc + w_term;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_step      <= '0;
            r_acc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_p     <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_id     <= w_grant;
                        r_acc    <= '0;
                        r_step   <= '0;
                        r_rr_ptr <= IDW'((32'(w_grant) + 32'd1) % NREQ);
                    end
                end
                S_MUL: begin
                    r_acc  <= w_sum;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_rsp_p     <= w_sum;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_p     = r_rsp_p;
    assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_mult4_seq_arb.sv
// Directed bench for mult4_seq_arb with two requesters and an ideal 4x4 core model.
module tb_mult4_seq_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [15:0] rsp_p;
    logic        busy;
    logic [3:0]  core_x;
    logic [3:0]  core_y;
    logic [7:0]  core_o;

    int total = 0;
    int bad   = 0;

    mult4_seq_arb #(.NREQ(2), .OPW(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy),
        .core_x(core_x), .core_y(core_y), .core_o(core_o)
    );

    assign core_o = 8'(core_x) * 8'(core_y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, 32'({rsp_valid, rsp_p, rsp_id, busy, req_ready, core_x, core_y}), 32'd0);
    endtask

    task automatic wait_ready(input string tag, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_ready_seen"}, 32'(ok), 32'd1);
    endtask

    // Single transaction from IDLE: checks grant, nibble order, latency, product, id.
    task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p, input int hold, input string tag);
        bit ok;
        bit core_bad;
        int c;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid[id]    = 1'b1;
        rsp_ready        = 1'b0;
        wait_ready(tag, ok);
        if (!ok) begin
            req_valid[id] = 1'b0;
            return;
        end
        chk({tag, "_grant"}, 32'(req_ready), 32'(2'b01 << id));
        @(negedge clk);
        req_valid[id] = 1'b0;
        c = 0;
        core_bad = 1'b0;
        while (!rsp_valid && c < 20) begin
            case (c)
                0: if ({core_x, core_y} !== {a[3:0], b[3:0]}) core_bad = 1'b1;
                1: if ({core_x, core_y} !== {a[3:0], b[7:4]}) core_bad = 1'b1;
                2: if ({core_x, core_y} !== {a[7:4], b[3:0]}) core_bad = 1'b1;
                3: if ({core_x, core_y} !== {a[7:4], b[7:4]}) core_bad = 1'b1;
                default: core_bad = 1'b1;
            endcase
            @(negedge clk);
            c++;
        end
        chk({tag, "_core_nibbles"}, 32'(core_bad), 32'd0);
        chk({tag, "_latency"}, 32'(c), 32'd4);
        chk({tag, "_p"}, 32'(rsp_p), 32'(exp_p));
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'({rsp_valid, busy}), 32'd0);
    endtask

    initial begin
        bit ok;
        bit viol;
        bit stable;
        int c;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] rp;

        rst = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset_idle");
        req_valid = 2'b11;
        #1;
        chk_reset_outputs("reset_ready_gated");
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic products and boundaries
        run_op(0, 8'h12, 8'h34, 16'h03A8, 0, "t1");
        run_op(1, 8'hFF, 8'hFF, 16'hFE01, 0, "t2_max");
        run_op(0, 8'h00, 8'hA5, 16'h0000, 1, "t2_zero");

        // Both requesters valid from reset: strict alternation
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_a = {8'hC8, 8'h0F};
        req_b = {8'h07, 8'h11};
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        viol = 1'b0;
        for (int t = 0; t < 6; t++) begin
            wait_ready($sformatf("t3_%0d", t), ok);
            if (!ok) break;
            chk($sformatf("t3_%0d_grant", t), 32'(req_ready), 32'(2'b01 << (t % 2)));
            @(negedge clk);
            chk($sformatf("t3_%0d_pulse", t), 32'(req_ready), 32'd0);
            c = 0;
            while (!rsp_valid && c < 20) begin
                if (busy && req_ready != 2'b00) viol = 1'b1;
                @(negedge clk);
                c++;
            end
            if (busy && req_ready != 2'b00) viol = 1'b1;
            chk($sformatf("t3_%0d_id", t), 32'(rsp_id), 32'(t % 2));
            chk($sformatf("t3_%0d_p", t), 32'(rsp_p), (t % 2 == 0) ? 32'h00FF : 32'h0578);
            @(negedge clk);
        end
        chk("t3_ready_while_busy", 32'(viol), 32'd0);
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        @(negedge clk);

        // Backpressure in DONE: 0xAB*0xCD = 0x88EF, held for five cycles
        req_a[7:0] = 8'hAB;
        req_b[7:0] = 8'hCD;
        req_valid  = 2'b01;
        wait_ready("t4", ok);
        @(negedge clk);
        req_valid = 2'b00;
        c = 0;
        while (!rsp_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("t4_latency", 32'(c), 32'd4);
        req_valid = 2'b10;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if ({rsp_valid, rsp_p, rsp_id, req_ready, busy} !== {1'b1, 16'h88EF, 1'b0, 2'b00, 1'b1})
                stable = 1'b0;
            @(negedge clk);
        end
        chk("t4_hold_stable", 32'(stable), 32'd1);
        chk("t4_p", 32'(rsp_p), 32'h88EF);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t4_release", 32'({rsp_valid, busy}), 32'd0);
        @(negedge clk);
        chk("t4_no_second_rsp", 32'(rsp_valid), 32'd0);

        // Reset during MUL step 2 aborts; req0 regains priority afterwards
        req_a[7:0] = 8'h55;
        req_b[7:0] = 8'h66;
        req_valid  = 2'b01;
        wait_ready("t5", ok);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        chk("t5_step2_core", 32'({busy, core_x, core_y}), 32'({1'b1, 4'h5, 4'h6}));
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        chk_reset_outputs("t5_async_reset");
        @(negedge clk);
        chk_reset_outputs("t5_reset_held");
        req_valid = 2'b00;
        rst = 1'b0;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) stable = 1'b0;
        end
        chk("t5_no_rsp_after_abort", 32'(stable), 32'd1);
        req_a = {8'h77, 8'h12};
        req_b = {8'h88, 8'h34};
        req_valid = 2'b11;
        #1;
        chk("t5_req0_priority", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        c = 0;
        while (!rsp_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("t5_fresh_p", 32'(rsp_p), 32'h03A8);
        chk("t5_fresh_id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Random operands, requesters and response stalls
        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rp = 16'(ra) * 16'(rb);
            run_op(int'($urandom_range(0, 1)), ra, rb, rp, int'($urandom_range(0, 3)),
                   $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
